// File: rtl/tdm_demux_1_8.sv
// tdm_demux_1_8
// Registered 1:8 time-division demultiplexer. It takes the serial slot
// stream of an 8:1 select mux (select stepped 0..7) and rebuilds the eight
// parallel channels. Frame alignment comes from a sync marker on slot 0.
//
// Ports
//   clk        : single rising-edge clock
//   rst_n      : asynchronous active-low reset
//   din        : serial slot data, WIDTH bits
//   din_valid  : din carries a slot beat this cycle
//   frame_sync : this beat is slot 0 (ignored when din_valid=0)
//   dout       : recovered frame, slot n at dout[n*WIDTH +: WIDTH]
//   dout_valid : one-cycle pulse when dout is updated
//   sel        : slot index expected for the next beat
//   locked     : frame alignment held
//   sync_err   : one-cycle pulse on an alignment violation
//   frame_cnt  : completed frames, saturating at 16'hFFFF
module tdm_demux_1_8 #(
  parameter int WIDTH            = 1,
  parameter bit SYNC_EVERY_FRAME = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     din,
  input  logic                 din_valid,
  input  logic                 frame_sync,
  output logic [8*WIDTH-1:0]   dout,
  output logic                 dout_valid,
  output logic [2:0]           sel,
  output logic                 locked,
  output logic                 sync_err,
  output logic [15:0]          frame_cnt
);

  localparam logic [0:0] ST_HUNT   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  logic [0:0]              state_q, state_d;
  logic [2:0]              sel_q, sel_d;
  logic [6:0][WIDTH-1:0]   shadow_q, shadow_d;
  logic [8*WIDTH-1:0]      dout_q, dout_d;
  logic                    dout_valid_q, dout_valid_d;
  logic                    sync_err_q, sync_err_d;
  logic [15:0]             frame_cnt_q, frame_cnt_d;

  // Next-state logic. Nothing moves unless a beat is present; the slot
  // counter doubles as the write pointer into the shadow register, and
  // slot 7 is never stored because it goes straight into dout with the
  // other seven slots.
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    shadow_d     = shadow_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    sync_err_d   = 1'b0;
    frame_cnt_d  = frame_cnt_q;

    if (din_valid) begin
      if (state_q == ST_HUNT) begin
        if (frame_sync) begin
          shadow_d[0] = din;
          sel_d       = 3'd1;
          state_d     = ST_LOCKED;
        end
      end else if (frame_sync) begin
        // A sync marker always realigns; off slot 0 it abandons the
        // partial frame and is flagged.
        if (sel_q != 3'd0) begin
          sync_err_d = 1'b1;
        end
        shadow_d[0] = din;
        sel_d       = 3'd1;
      end else if (sel_q == 3'd0 && SYNC_EVERY_FRAME) begin
        sync_err_d = 1'b1;
        state_d    = ST_HUNT;
        sel_d      = 3'd0;
      end else if (sel_q == 3'd7) begin
        dout_d       = {din, shadow_q};
        dout_valid_d = 1'b1;
        sel_d        = 3'd0;
        if (frame_cnt_q != 16'hFFFF) begin
          frame_cnt_d = frame_cnt_q + 16'd1;
        end
      end else begin
        for (int i = 0; i < 7; i++) begin
          if (sel_q == 3'(i)) begin
            shadow_d[i] = din;
          end
        end
        sel_d = sel_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_HUNT;
      sel_q        <= '0;
      shadow_q     <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      sync_err_q   <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      shadow_q     <= shadow_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      sync_err_q   <= sync_err_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign sel        = sel_q;
  assign locked     = (state_q == ST_LOCKED);
  assign sync_err   = sync_err_q;
  assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_tdm_demux_1_8.sv
// tb_tdm_demux_1_8
// Drives two instances from the same stimulus: instance 0 flywheels
// (SYNC_EVERY_FRAME=0), instance 1 demands sync on every frame. A
// slot-counting model per instance predicts every output each cycle, and
// hand-computed literals pin the model at key points.
module tb_tdm_demux_1_8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [0:0]  din = '0;
  logic        din_valid = 1'b0;
  logic        frame_sync = 1'b0;
  logic        check_en = 1'b0;

  logic [7:0]  dout0, dout1;
  logic        dv0, dv1, lk0, lk1, se0, se1;
  logic [2:0]  sel0, sel1;
  logic [15:0] cnt0, cnt1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  tdm_demux_1_8 #(.WIDTH(1), .SYNC_EVERY_FRAME(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
    .frame_sync(frame_sync), .dout(dout0), .dout_valid(dv0), .sel(sel0),
    .locked(lk0), .sync_err(se0), .frame_cnt(cnt0)
  );

  tdm_demux_1_8 #(.WIDTH(1), .SYNC_EVERY_FRAME(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
    .frame_sync(frame_sync), .dout(dout1), .dout_valid(dv1), .sel(sel1),
    .locked(lk1), .sync_err(se1), .frame_cnt(cnt1)
  );

  // Model: per instance, the bits gathered so far in the current frame and
  // how many there are; a frame is emitted once eight have been gathered.
  logic [7:0] m_bits [2];
  int         m_n    [2];
  logic       m_lock [2];
  logic [7:0] m_dout [2];
  logic       m_dv   [2];
  logic       m_err  [2];
  int         m_cnt  [2];

  always @(posedge clk or negedge rst_n) begin
    for (int m = 0; m < 2; m++) begin
      if (!rst_n) begin
        m_bits[m] = '0; m_n[m] = 0; m_lock[m] = 1'b0;
        m_dout[m] = '0; m_dv[m] = 1'b0; m_err[m] = 1'b0; m_cnt[m] = 0;
      end else begin
        m_dv[m]  = 1'b0;
        m_err[m] = 1'b0;
        if (din_valid) begin
          if (!m_lock[m]) begin
            if (frame_sync) begin
              m_bits[m][0] = din[0]; m_n[m] = 1; m_lock[m] = 1'b1;
            end
          end else if (frame_sync) begin
            if (m_n[m] != 0) m_err[m] = 1'b1;
            m_bits[m][0] = din[0]; m_n[m] = 1;
          end else if (m_n[m] == 0 && m == 1) begin
            m_err[m] = 1'b1; m_lock[m] = 1'b0;
          end else begin
            m_bits[m][m_n[m]] = din[0];
            m_n[m] = m_n[m] + 1;
            if (m_n[m] == 8) begin
              m_dout[m] = m_bits[m];
              m_dv[m]   = 1'b1;
              m_n[m]    = 0;
              if (m_cnt[m] < 65535) m_cnt[m] = m_cnt[m] + 1;
            end
          end
        end
      end
    end
  end

  task automatic check_output(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (check_en) begin
      check_output("dout0",   32'(dout0), 32'(m_dout[0]));
      check_output("dv0",     32'(dv0),   32'(m_dv[0]));
      check_output("sel0",    32'(sel0),  32'(m_n[0]));
      check_output("locked0", 32'(lk0),   32'(m_lock[0]));
      check_output("err0",    32'(se0),   32'(m_err[0]));
      check_output("cnt0",    32'(cnt0),  32'(m_cnt[0]));
      check_output("dout1",   32'(dout1), 32'(m_dout[1]));
      check_output("dv1",     32'(dv1),   32'(m_dv[1]));
      check_output("sel1",    32'(sel1),  32'(m_n[1]));
      check_output("locked1", 32'(lk1),   32'(m_lock[1]));
      check_output("err1",    32'(se1),   32'(m_err[1]));
      check_output("cnt1",    32'(cnt1),  32'(m_cnt[1]));
    end
  end

  // One beat presented across a single rising edge, then an idle gap.
  // Called and returns at a falling edge.
  task automatic apply_stimulus(input logic d, input logic fs, input int gap);
    din        = d;
    frame_sync = fs;
    din_valid  = 1'b1;
    @(negedge clk);
    din_valid  = 1'b0;
    frame_sync = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  logic [7:0] pat;
  logic [7:0] d_word;

  initial begin
    repeat (2) @(negedge clk);
    check_output("rst_sel",    32'(sel0),  32'd0);
    check_output("rst_locked", 32'(lk0),   32'd0);
    check_output("rst_dout",   32'(dout0), 32'd0);
    check_output("rst_cnt",    32'(cnt1),  32'd0);
    rst_n    = 1'b1;
    check_en = 1'b1;

    // Pre-lock beats are ignored, then the basic frame.
    for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 1'b0, 0);
    check_output("prelock_locked", 32'(lk0), 32'd0);
    pat = 8'b01001101;
    apply_stimulus(pat[0], 1'b1, 0);
    check_output("lock_rise", 32'(lk0), 32'd1);
    for (int i = 1; i < 8; i++) apply_stimulus(pat[i], 1'b0, 0);
    check_output("basic_dv",   32'(dv0),   32'd1);
    check_output("basic_dout", 32'(dout0), 32'h4D);
    check_output("basic_cnt",  32'(cnt1),  32'd1);
    @(negedge clk);
    check_output("basic_dv_pulse", 32'(dv0), 32'd0);

    // Same frame with 0..3 idle cycles between beats.
    for (int i = 0; i < 8; i++) apply_stimulus(pat[i], i == 0, i % 4);
    check_output("gap_dout", 32'(dout1), 32'h4D);
    check_output("gap_cnt",  32'(cnt0),  32'd2);

    // Early sync at sel=4, then a fresh frame 0,1,1,1,1,1,1,1.
    apply_stimulus(1'b1, 1'b1, 0);
    for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 1'b0, 0);
    apply_stimulus(1'b0, 1'b1, 0);
    check_output("early_err", 32'(se0),  32'd1);
    check_output("early_sel", 32'(sel1), 32'd1);
    for (int i = 0; i < 7; i++) apply_stimulus(1'b1, 1'b0, 0);
    check_output("early_dout", 32'(dout0), 32'hFE);
    check_output("early_cnt",  32'(cnt0),  32'd3);

    // A synced frame followed by one without sync.
    pat = 8'b00111010;
    for (int i = 0; i < 8; i++) apply_stimulus(pat[i], i == 0, 0);
    apply_stimulus(1'b1, 1'b0, 0);
    check_output("strict_err",    32'(se1), 32'd1);
    check_output("flywheel_err",  32'(se0), 32'd0);
    for (int i = 1; i < 8; i++) apply_stimulus(1'b1, 1'b0, 0);
    check_output("strict_locked", 32'(lk1),   32'd0);
    check_output("strict_dout",   32'(dout1), 32'h3A);
    check_output("strict_cnt",    32'(cnt1),  32'd4);
    check_output("flywheel_dout", 32'(dout0), 32'hFF);
    check_output("flywheel_cnt",  32'(cnt0),  32'd5);

    // Round trip through an 8:1 mux with the select stepped 0..7.
    d_word = 8'b10110001;
    for (int s = 0; s < 8; s++) apply_stimulus(d_word[s], s == 0, 0);
    check_output("rt_dout0", 32'(dout0), 32'hB1);
    check_output("rt_dout1", 32'(dout1), 32'hB1);

    // Reset mid-frame at sel=5 clears everything without waiting for a clock.
    for (int s = 0; s < 5; s++) apply_stimulus(d_word[s], s == 0, 0);
    check_output("pre_rst_sel", 32'(sel0), 32'd5);
    #2 rst_n = 1'b0;
    #1;
    check_output("mid_rst_sel",    32'(sel0),  32'd0);
    check_output("mid_rst_locked", 32'(lk1),   32'd0);
    check_output("mid_rst_dout",   32'(dout0), 32'd0);
    check_output("mid_rst_cnt",    32'(cnt0),  32'd0);
    check_output("mid_rst_dv",     32'(dv1),   32'd0);
    check_output("mid_rst_err",    32'(se1),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    check_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
